// File: rtl/ann_pkg.sv
// Shared ANN datapath definitions: default widths, counter index width
// and the neuron sequencer FSM state encoding.
package ann_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/neuron_mult.sv
// Combinational signed DATA_W x DATA_W multiplier.
// The full-precision product is sign-extended to ACC_W.
module neuron_mult
    import ann_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_p
);

    logic signed [2*DATA_W-1:0] w_full;

    assign w_full = i_a * i_b;
    assign o_p    = {{(ACC_W-2*DATA_W){w_full[2*DATA_W-1]}}, w_full};

endmodule

// File: rtl/neuron_mac_seq.sv
// Single-neuron MAC sequencer fed by the 4-bit term counter.
// Define NEURON_RELU_EN to apply ReLU to the result loaded into y.
module neuron_mac_seq
    import ann_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = 9
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [IDX_W-1:0]         idx,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  y,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic                     cnt_res,
    output logic                     err_seq
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_exp_idx;
    logic signed [ACC_W-1:0]  r_y;
    logic                     r_y_valid;
    logic                     r_cnt_res;
    logic                     r_err_seq;

    state_t                   w_state_nx;
    logic signed [ACC_W-1:0]  w_acc_nx;
    logic [IDX_W-1:0]         w_exp_idx_nx;
    logic signed [ACC_W-1:0]  w_y_nx;
    logic                     w_y_valid_nx;
    logic                     w_cnt_res_nx;
    logic                     w_err_seq_nx;

    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic                     w_accept;

    function automatic logic signed [ACC_W-1:0] act(
        input logic signed [ACC_W-1:0] v
    );
`ifdef NEURON_RELU_EN
        return v[ACC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    neuron_mult #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .i_a (x_in),
        .i_b (w_in),
        .o_p (w_prod)
    );

    assign in_ready  = (r_state != DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_acc_sum = r_acc + w_prod;

    always_comb begin
        w_state_nx   = r_state;
        w_acc_nx     = r_acc;
        w_exp_idx_nx = r_exp_idx;
        w_y_nx       = r_y;
        w_y_valid_nx = r_y_valid;
        w_cnt_res_nx = 1'b0;
        w_err_seq_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (idx == '0) begin
                        w_acc_nx     = w_prod;
                        w_exp_idx_nx = IDX_W'(1);
                        if (N_TERMS == 1) begin
                            w_state_nx   = DONE;
                            w_y_nx       = act(w_prod);
                            w_y_valid_nx = 1'b1;
                        end else begin
                            w_state_nx = ACCUM;
                        end
                    end else begin
                        w_err_seq_nx = 1'b1;
                        w_cnt_res_nx = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (idx == r_exp_idx) begin
                        w_acc_nx     = w_acc_sum;
                        w_exp_idx_nx = r_exp_idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            w_state_nx   = DONE;
                            w_y_nx       = act(w_acc_sum);
                            w_y_valid_nx = 1'b1;
                        end
                    end else begin
                        // Out-of-order term: drop the partial sum and
                        // restart the counter so both sides resync at 0.
                        w_acc_nx     = '0;
                        w_exp_idx_nx = '0;
                        w_err_seq_nx = 1'b1;
                        w_cnt_res_nx = 1'b1;
                        w_state_nx   = IDLE;
                    end
                end
            end
            DONE: begin
                if (r_y_valid && y_ready) begin
                    w_y_valid_nx = 1'b0;
                    w_cnt_res_nx = 1'b1;
                    w_acc_nx     = '0;
                    w_exp_idx_nx = '0;
                    w_state_nx   = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_exp_idx <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_cnt_res <= 1'b1;
            r_err_seq <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_acc     <= w_acc_nx;
            r_exp_idx <= w_exp_idx_nx;
            r_y       <= w_y_nx;
            r_y_valid <= w_y_valid_nx;
            r_cnt_res <= w_cnt_res_nx;
            r_err_seq <= w_err_seq_nx;
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign cnt_res = r_cnt_res;
    assign err_seq = r_err_seq;

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Single-neuron multiply-accumulate sequencer; sits directly downstream of the 4-bit term counter in the ANN datapath.
- Consumes the counter's term index together with one streamed (input, weight) pair per term.
- Accumulates N_TERMS signed products and presents the neuron pre-activation sum on a valid/ready output.
- Drives the counter's reset at the end of every neuron or on a sequence error.

Parameters:
- DATA_W, 8, signed width of x_in and w_in.
- ACC_W, 20, signed accumulator/output width; must be at least 2*DATA_W+4.
- N_TERMS, 9, number of terms per neuron; legal range 1..16 (4-bit index).

Ports:
- clk  in  1  system clock; all logic on posedge.
- res  in  1  synchronous, active-high reset.
- idx  in  4  term index from the upstream counter's c_out.
- x_in  in  DATA_W  signed neuron input for term idx.
- w_in  in  DATA_W  signed weight for term idx.
- in_valid  in  1  x_in/w_in/idx valid this cycle.
- in_ready  out  1  block can accept a term.
- y  out  ACC_W  signed neuron result.
- y_valid  out  1  y holds a completed result.
- y_ready  in  1  downstream accepts y.
- cnt_res  out  1  registered one-cycle pulse that resets the upstream counter.
- err_seq  out  1  registered one-cycle pulse on an index sequence error.

Behaviour:
- Reset (res=1 at posedge) has priority over everything and may occur mid-operation:
  - state<=IDLE, acc<=0, exp_idx<=0, y<=0.
  - y_valid<=0, cnt_res<=1 (so the counter restarts cleanly), err_seq<=0.
- Accept condition: in_valid && in_ready; in_ready=1 in IDLE and ACCUM, 0 in DONE.
- Product: full-precision signed DATA_W x DATA_W, sign-extended to ACC_W; acc wraps modulo 2^ACC_W (cannot overflow at legal parameters).
- FSM state IDLE:
  - Accepted term with idx==0: acc<=product, exp_idx<=1; next state ACCUM, or DONE when N_TERMS==1.
  - Accepted term with idx!=0: discarded; err_seq and cnt_res pulse; stay IDLE.
- FSM state ACCUM:
  - Accepted term with idx==exp_idx: acc<=acc+product, exp_idx<=exp_idx+1.
  - If idx==N_TERMS-1 on that term, go to DONE.
  - Accepted term with idx!=exp_idx: acc discarded; err_seq and cnt_res pulse; go to IDLE.
  - in_valid low: hold all state; no timeout.
- FSM state DONE:
  - y and y_valid are registered; y_valid rises exactly 1 cycle after the last term is accepted.
  - y stays stable while y_valid && !y_ready.
  - On y_valid && y_ready: y_valid<=0, cnt_res pulses, go to IDLE.
  - in_valid is ignored in DONE.
- y_ready while y_valid=0 has no effect.
- cnt_res and err_seq are each high for exactly one cycle per event.
- Minimum throughput: N_TERMS accept cycles + 1 output cycle per neuron.

Optional Feature:
- Macro NEURON_RELU_EN.
- Defined: y<=(acc<0)?0:acc when loaded into DONE, i.e. ReLU activation.
- Undefined: y<=acc raw signed sum.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package ann_pkg holds:
  - DATA_W/ACC_W defaults.
  - FSM state localparams IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - IDX_W=4, matching the counter width.
- One natural sub-module: neuron_mult, a combinational signed multiplier with sign extension to ACC_W, reusable by other neuron blocks.
- FSM and accumulator stay in neuron_mac_seq.

Test Plan:
- N_TERMS=4, idx 0..3, x={1,2,3,4}, w={5,-1,2,1}, y_ready=1 -> y=13, y_valid high 1 cycle after idx 3, then cnt_res pulses once.
- N_TERMS=4, x=3 all terms, w=-2 all terms -> y=-24 (20'hFFFE8) without NEURON_RELU_EN; y=0 with it.
- N_TERMS=16, x=-128, w=-128 on every term -> y=262144, no wrap.
- Backpressure: y_ready held low 5 cycles after completion -> y_valid and y stable, in_ready=0, in_valid ignored; completes on the first y_ready=1 cycle.
- Sequence error: idx 0,1,3 -> err_seq and cnt_res pulse on the idx-3 cycle, state IDLE, no y_valid; a fresh 0..N-1 sequence then yields the correct sum.
- res asserted after idx 2 of 4 -> next cycle y_valid=0, acc=0, in_ready=1; the next full sequence produces an uncorrupted result.
